gremlin_scheduler: RTL and testbench
====================================

# gremlin_scheduler

Lifecycle controller for the two gremlins consumed by the collision block. It owns each gremlin's state (absent, alive and moving, tombstone, waiting to respawn) and drives the 24-bit gremlin words. It arbitrates a single shared LFSR spawn generator between the two gremlins. Hit pulses from the collision/scoring path drive it, and it advances on the per-frame tick.

## Interface
- TOMB_FRAMES, 120: frame ticks a killed gremlin stays as a tombstone.
- RESPAWN_FRAMES, 60: frame ticks a gremlin stays absent before respawning.
- X_MIN, 64: left spawn/motion bound; X_MAX = X_MIN+511; X_MIN+511 ≤ 2047.
- Y_MIN, 64: top spawn/motion bound; Y_MAX = Y_MIN+255.
- STEP, 1: pixels moved per frame tick on each axis (1..15).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- game_en  in  1  level; gremlins exist only while high.
- grem0_hit, grem1_hit  in  1  one-cycle kill pulse per gremlin.
- grem0, grem1  out  24  {present[23], x[22:12], y[11:1], alive[0]}.
- grem0_state, grem1_state  out  2  00 IDLE, 01 ALIVE, 10 DEAD, 11 WAIT.

## Operation
- Per-gremlin FSM with states IDLE, ALIVE, DEAD and WAIT. Both instances are identical; each has a 7-bit frame counter and direction bits dx and dy (1 = increasing).
- IDLE: the word is 24'h0.
  - The gremlin leaves IDLE when game_en is high and it is granted the spawn generator.
- SPAWN on grant: with L = the current LFSR value,
  - x = X_MIN + L[8:0]; y = Y_MIN + L[15:8];
  - dx = L[9]; dy = L[0];
  - state becomes ALIVE and the counter clears.
- ALIVE: the word is {1, x, y, 1}. On frame_tick each axis moves ±STEP.
  - If the move would leave [MIN, MAX] on an axis, that axis flips direction and holds for that tick.
  - On grem*_hit the gremlin goes to DEAD and position freezes.
- DEAD: the word is {1, x, y, 0} (tombstone). frame_tick increments the counter.
  - On the tick where the counter reaches TOMB_FRAMES, state becomes WAIT and the counter clears.
- WAIT: the word is 24'h0. frame_tick increments the counter.
  - On the tick reaching RESPAWN_FRAMES, the gremlin raises a spawn request.
  - It stays in WAIT with the word at 0 until granted, then spawns as above.
- Spawn arbiter: one grant per cycle, fixed priority.
  - grem0 has priority over grem1.
  - The loser keeps requesting and is granted the next cycle.
  - A spawn request from IDLE is raised whenever game_en is high.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  - Seed 16'hACE1 on rst; it advances every clk cycle.
  - The value sampled at a grant is the pre-advance value.
- game_en low: every FSM goes to IDLE on the next edge, counters clear, and pending requests drop. The LFSR keeps running.
- A hit while not ALIVE is ignored.

## Timing
- Reset values:
  - grem0 and grem1 are 24'h0.
  - Both state outputs are 00.
  - Counters and direction bits are 0.
  - LFSR is 16'hACE1.
- All outputs are registered.
- Hit latency: a hit pulse at edge n gives alive=0 and state=DEAD at edge n+1.
- Spawn latency: game_en rising at edge n gives grem0 spawned at n+1 and grem1 spawned at n+2.
- Movement: the position updates on the edge after the frame_tick cycle.
- Simultaneous events:
  - Hit and frame_tick in the same cycle: the hit wins and there is no move that tick.
  - Counter terminal tick and game_en low in the same cycle: game_en wins and the gremlin goes to IDLE.
  - rst and any input together: rst wins.
- rst mid-operation returns to the full reset state on the next edge.
- Counter width is 7 bits. TOMB_FRAMES and RESPAWN_FRAMES are limited to 1..127; 0 is illegal.

## Test plan
- Reset, then game_en=1 at cycle 10:
  - grem0 spawns at cycle 11 and grem1 at cycle 12, both with bit23=1 and bit0=1.
  - Positions match the LFSR model (seed ACE1) and lie within [64,575]×[64,319].
- TOMB_FRAMES=3, RESPAWN_FRAMES=2; pulse grem0_hit:
  - grem0 shows {1, x, y, 0} for exactly 3 ticks, then 0 for 2 ticks.
  - It respawns on the edge after the 2nd WAIT tick. grem1 is unaffected throughout.
- Both gremlins reach the WAIT terminal tick on the same frame_tick:
  - grem0 respawns one cycle after the tick; grem1 respawns one cycle later.
  - Each takes a distinct, consecutive LFSR value.
- Bounce: force a spawn at x=X_MAX-1 with dx=1 and STEP=1.
  - Tick 1 gives x=575; tick 2 holds x=575 with dx=0; tick 3 gives x=574.
- Hit on the same cycle as frame_tick while ALIVE: position is unchanged and alive=0 next edge.
- Hit while in DEAD or WAIT: no change.
- Drop game_en while grem0 is DEAD and grem1 is ALIVE: both words are 0 and both states 00 on the next edge.
- Assert rst mid-WAIT: all outputs return to reset values next edge, and the LFSR restarts at ACE1.

Source files
------------

// File: rtl/gremlin_scheduler.sv
// Lifecycle controller for two gremlins. It steps each gremlin through idle, alive, tombstone and respawn-wait.
// It also arbitrates one shared LFSR spawn source between the gremlins, and all outputs are registered.
module gremlin_scheduler #(
  parameter int TOMB_FRAMES    = 120,
  parameter int RESPAWN_FRAMES = 60,
  parameter int X_MIN          = 64,
  parameter int Y_MIN          = 64,
  parameter int STEP           = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        game_en,
  input  logic        grem0_hit,
  input  logic        grem1_hit,
  output logic [23:0] grem0,
  output logic [23:0] grem1,
  output logic [1:0]  grem0_state,
  output logic [1:0]  grem1_state
);

  localparam logic [10:0] XMIN_C    = 11'(X_MIN);
  localparam logic [10:0] XMAX_C    = 11'(X_MIN + 511);
  localparam logic [10:0] YMIN_C    = 11'(Y_MIN);
  localparam logic [10:0] YMAX_C    = 11'(Y_MIN + 255);
  localparam logic [10:0] STEP_C    = 11'(STEP);
  localparam logic [6:0]  TOMB_C    = 7'(TOMB_FRAMES);
  localparam logic [6:0]  RESPAWN_C = 7'(RESPAWN_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ALIVE = 2'b01,
    ST_DEAD  = 2'b10,
    ST_WAIT  = 2'b11
  } gstate_t;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [1:0]  hit;
  logic [1:0]  req;
  logic [1:0]  grant;

  gstate_t     st_q   [2];
  gstate_t     st_d   [2];
  logic [6:0]  cnt_q  [2];
  logic [6:0]  cnt_d  [2];
  logic [10:0] x_q    [2];
  logic [10:0] x_d    [2];
  logic [10:0] y_q    [2];
  logic [10:0] y_d    [2];
  logic [23:0] word_q [2];
  logic [23:0] word_d [2];
  logic [1:0]  dx_q, dx_d, dy_q, dy_d, pend_q, pend_d;

  assign hit     = {grem1_hit, grem0_hit};
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Requests depend only on registered state and inputs, so the grant never loops back into them.
  always_comb begin
    req = 2'b00;
    for (int g = 0; g < 2; g++) begin
      if (game_en) begin
        case (st_q[g])
          ST_IDLE: req[g] = 1'b1;
          ST_WAIT: req[g] = pend_q[g] || (frame_tick && (7'(cnt_q[g] + 7'd1) == RESPAWN_C));
          default: req[g] = 1'b0;
        endcase
      end
    end
  end

  assign grant[0] = req[0];
  assign grant[1] = req[1] & ~req[0];

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      st_d[g]   = st_q[g];
      cnt_d[g]  = cnt_q[g];
      x_d[g]    = x_q[g];
      y_d[g]    = y_q[g];
      dx_d[g]   = dx_q[g];
      dy_d[g]   = dy_q[g];
      pend_d[g] = pend_q[g];

      if (!game_en) begin
        st_d[g]   = ST_IDLE;
        cnt_d[g]  = 7'd0;
        pend_d[g] = 1'b0;
      end else if (grant[g]) begin
        st_d[g]   = ST_ALIVE;
        cnt_d[g]  = 7'd0;
        pend_d[g] = 1'b0;
        x_d[g]    = XMIN_C + {2'b00, lfsr[8:0]};
        y_d[g]    = YMIN_C + {3'b000, lfsr[15:8]};
        dx_d[g]   = lfsr[9];
        dy_d[g]   = lfsr[0];
      end else begin
        case (st_q[g])
          ST_ALIVE: begin
            if (hit[g]) begin
              st_d[g]  = ST_DEAD;
              cnt_d[g] = 7'd0;
            end else if (frame_tick) begin
              // A move that would cross a bound flips direction and holds for this tick.
              if (dx_q[g]) begin
                if (x_q[g] > XMAX_C - STEP_C) dx_d[g] = 1'b0;
                else                          x_d[g]  = x_q[g] + STEP_C;
              end else begin
                if (x_q[g] < XMIN_C + STEP_C) dx_d[g] = 1'b1;
                else                          x_d[g]  = x_q[g] - STEP_C;
              end
              if (dy_q[g]) begin
                if (y_q[g] > YMAX_C - STEP_C) dy_d[g] = 1'b0;
                else                          y_d[g]  = y_q[g] + STEP_C;
              end else begin
                if (y_q[g] < YMIN_C + STEP_C) dy_d[g] = 1'b1;
                else                          y_d[g]  = y_q[g] - STEP_C;
              end
            end
          end
          ST_DEAD: begin
            if (frame_tick) begin
              if (7'(cnt_q[g] + 7'd1) == TOMB_C) begin
                st_d[g]  = ST_WAIT;
                cnt_d[g] = 7'd0;
              end else begin
                cnt_d[g] = cnt_q[g] + 7'd1;
              end
            end
          end
          ST_WAIT: begin
            // The terminal tick latches a pending request when the other gremlin wins the arbiter.
            if (frame_tick && !pend_q[g]) begin
              if (7'(cnt_q[g] + 7'd1) == RESPAWN_C) begin
                pend_d[g] = 1'b1;
                cnt_d[g]  = 7'd0;
              end else begin
                cnt_d[g] = cnt_q[g] + 7'd1;
              end
            end
          end
          default: ;
        endcase
      end

      case (st_d[g])
        ST_ALIVE: word_d[g] = {1'b1, x_d[g], y_d[g], 1'b1};
        ST_DEAD:  word_d[g] = {1'b1, x_d[g], y_d[g], 1'b0};
        default:  word_d[g] = 24'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= 16'hACE1;
      dx_q   <= 2'b00;
      dy_q   <= 2'b00;
      pend_q <= 2'b00;
      for (int g = 0; g < 2; g++) begin
        st_q[g]   <= ST_IDLE;
        cnt_q[g]  <= 7'd0;
        x_q[g]    <= 11'd0;
        y_q[g]    <= 11'd0;
        word_q[g] <= 24'h0;
      end
    end else begin
      lfsr   <= {lfsr_fb, lfsr[15:1]};
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      pend_q <= pend_d;
      for (int g = 0; g < 2; g++) begin
        st_q[g]   <= st_d[g];
        cnt_q[g]  <= cnt_d[g];
        x_q[g]    <= x_d[g];
        y_q[g]    <= y_d[g];
        word_q[g] <= word_d[g];
      end
    end
  end

  assign grem0       = word_q[0];
  assign grem1       = word_q[1];
  assign grem0_state = st_q[0];
  assign grem1_state = st_q[1];

endmodule

// File: tb/tb_gremlin_scheduler.sv
// Directed bench for gremlin_scheduler with short tombstone and respawn windows.
module tb_gremlin_scheduler;

  localparam int XMIN = 64;
  localparam int XMAX = 575;
  localparam int YMIN = 64;
  localparam int YMAX = 319;

  logic        clk = 1'b0;
  logic        rst, frame_tick, game_en, grem0_hit, grem1_hit;
  logic [23:0] grem0, grem1;
  logic [1:0]  grem0_state, grem1_state;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_lfsr = 16'h0;
  logic [15:0] last_l = 16'h0;
  logic [10:0] mx [2];
  logic [10:0] my [2];
  logic        mdx [2];
  logic        mdy [2];
  logic        mal [2];
  logic        found;

  gremlin_scheduler #(
    .TOMB_FRAMES(3),
    .RESPAWN_FRAMES(2),
    .X_MIN(64),
    .Y_MIN(64),
    .STEP(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .game_en(game_en),
    .grem0_hit(grem0_hit),
    .grem1_hit(grem1_hit),
    .grem0(grem0),
    .grem1(grem1),
    .grem0_state(grem0_state),
    .grem1_state(grem1_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] adv(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  function automatic logic [23:0] mk(input logic [10:0] x, input logic [10:0] y, input logic a);
    return {1'b1, x, y, a};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; the model LFSR records the value the DUT sampled at that edge.
  task automatic step();
    @(posedge clk);
    last_l = m_lfsr;
    if (rst) m_lfsr = 16'hACE1;
    else     m_lfsr = adv(m_lfsr);
    @(negedge clk);
  endtask

  task automatic spawn_m(input int g, input logic [15:0] l);
    mx[g]  = 11'(XMIN + int'(l[8:0]));
    my[g]  = 11'(YMIN + int'(l[15:8]));
    mdx[g] = l[9];
    mdy[g] = l[0];
    mal[g] = 1'b1;
  endtask

  task automatic axis(inout logic [10:0] p, inout logic d, input int lo, input int hi);
    if (d) begin
      if (int'(p) + 1 > hi) d = 1'b0;
      else                  p = p + 11'd1;
    end else begin
      if (int'(p) - 1 < lo) d = 1'b1;
      else                  p = p - 11'd1;
    end
  endtask

  task automatic tick();
    for (int g = 0; g < 2; g++) begin
      if (mal[g]) begin
        axis(mx[g], mdx[g], XMIN, XMAX);
        axis(my[g], mdy[g], YMIN, YMAX);
      end
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; game_en = 1'b0; grem0_hit = 1'b0; grem1_hit = 1'b0;
    mal[0] = 1'b0; mal[1] = 1'b0;
    @(negedge clk);
    step(); step(); step();
    rst = 1'b0;
    chk("rst_grem0", grem0, 24'h0);
    chk("rst_grem1", grem1, 24'h0);
    chk("rst_state0", 24'(grem0_state), 24'd0);
    chk("rst_state1", 24'(grem1_state), 24'd0);

    repeat (9) step();
    chk("idle_state0", 24'(grem0_state), 24'd0);
    game_en = 1'b1;
    step();
    spawn_m(0, last_l);
    chk("spawn_grem0", grem0, mk(mx[0], my[0], 1'b1));
    chk("spawn_state0", 24'(grem0_state), 24'd1);
    chk("spawn_grem1_pending", grem1, 24'h0);
    step();
    spawn_m(1, last_l);
    chk("spawn_grem1", grem1, mk(mx[1], my[1], 1'b1));
    chk("spawn_state1", 24'(grem1_state), 24'd1);
    chk("range_x0", 24'(grem0[22:12] >= 11'd64 && grem0[22:12] <= 11'd575), 24'd1);
    chk("range_y1", 24'(grem1[11:1] >= 11'd64 && grem1[11:1] <= 11'd319), 24'd1);

    step();
    tick();
    chk("move1_grem0", grem0, mk(mx[0], my[0], 1'b1));
    chk("move1_grem1", grem1, mk(mx[1], my[1], 1'b1));
    tick();
    chk("move2_grem0", grem0, mk(mx[0], my[0], 1'b1));

    // Hit together with a tick: the hit wins and grem0 does not move.
    grem0_hit = 1'b1; mal[0] = 1'b0;
    tick();
    grem0_hit = 1'b0;
    chk("hit_tick_grem0", grem0, mk(mx[0], my[0], 1'b0));
    chk("hit_tick_state0", 24'(grem0_state), 24'd2);
    chk("hit_tick_grem1", grem1, mk(mx[1], my[1], 1'b1));

    tick();
    chk("tomb1_grem0", grem0, mk(mx[0], my[0], 1'b0));
    grem0_hit = 1'b1;
    step();
    grem0_hit = 1'b0;
    chk("dead_hit_grem0", grem0, mk(mx[0], my[0], 1'b0));
    chk("dead_hit_state0", 24'(grem0_state), 24'd2);
    tick();
    chk("tomb2_grem0", grem0, mk(mx[0], my[0], 1'b0));
    chk("tomb2_grem1", grem1, mk(mx[1], my[1], 1'b1));
    tick();
    chk("wait_state0", 24'(grem0_state), 24'd3);
    chk("wait_grem0", grem0, 24'h0);
    grem0_hit = 1'b1;
    step();
    grem0_hit = 1'b0;
    chk("wait_hit_state0", 24'(grem0_state), 24'd3);
    tick();
    chk("wait1_state0", 24'(grem0_state), 24'd3);
    chk("wait1_grem0", grem0, 24'h0);
    tick();
    spawn_m(0, last_l);
    chk("respawn_grem0", grem0, mk(mx[0], my[0], 1'b1));
    chk("respawn_grem1", grem1, mk(mx[1], my[1], 1'b1));

    // Both gremlins reach the respawn terminal tick together.
    grem0_hit = 1'b1; grem1_hit = 1'b1; mal[0] = 1'b0; mal[1] = 1'b0;
    step();
    grem0_hit = 1'b0; grem1_hit = 1'b0;
    chk("both_dead", 24'({grem0_state, grem1_state}), 24'h0A);
    tick(); tick(); tick();
    chk("both_wait", 24'({grem0_state, grem1_state}), 24'h0F);
    tick(); tick();
    spawn_m(0, last_l);
    chk("tie_grem0", grem0, mk(mx[0], my[0], 1'b1));
    chk("tie_state1", 24'(grem1_state), 24'd3);
    chk("tie_grem1_zero", grem1, 24'h0);
    step();
    spawn_m(1, last_l);
    chk("tie_grem1", grem1, mk(mx[1], my[1], 1'b1));

    // Drop game_en with grem0 dead and grem1 alive.
    grem0_hit = 1'b1; mal[0] = 1'b0;
    step();
    grem0_hit = 1'b0;
    chk("pre_drop_states", 24'({grem0_state, grem1_state}), 24'h09);
    game_en = 1'b0; mal[1] = 1'b0;
    step();
    chk("drop_grem0", grem0, 24'h0);
    chk("drop_grem1", grem1, 24'h0);
    chk("drop_states", 24'({grem0_state, grem1_state}), 24'h00);

    // Time the enable so grem0 spawns at x=574 heading right.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (m_lfsr[9:0] == 10'h3FE) begin
        game_en = 1'b1;
        step();
        found = 1'b1;
      end else begin
        step();
      end
    end
    chk("bounce_found", 24'(found), 24'd1);
    spawn_m(0, last_l);
    chk("bounce_x0", 24'(grem0[22:12]), 24'd574);
    step();
    spawn_m(1, last_l);
    tick();
    chk("bounce_tick1", 24'(grem0[22:12]), 24'd575);
    tick();
    chk("bounce_tick2", 24'(grem0[22:12]), 24'd575);
    tick();
    chk("bounce_tick3", 24'(grem0[22:12]), 24'd574);
    chk("bounce_word", grem0, mk(mx[0], my[0], 1'b1));

    // Reset while grem0 waits; the LFSR restarts at ACE1.
    grem0_hit = 1'b1; mal[0] = 1'b0;
    step();
    grem0_hit = 1'b0;
    tick(); tick(); tick();
    chk("prerst_state0", 24'(grem0_state), 24'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_grem0", grem0, 24'h0);
    chk("midrst_grem1", grem1, 24'h0);
    chk("midrst_states", 24'({grem0_state, grem1_state}), 24'h00);
    step();
    chk("ace1_grem0", grem0, 24'h9211D9);
    chk("ace1_state0", 24'(grem0_state), 24'd1);
    step();
    chk("next_grem1", grem1, 24'h8B012D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
